// File: rtl/freq_meter.sv
// freq_meter: measures a slow square wave against the system clock.
// Opens a gate of GATE_CYCLES clkin cycles and counts the rising edges of
// sig_in inside it. It also measures the distance, in clkin cycles, between
// the last two rising edges in that gate. Results are latched at the end of
// each completed gate.
// Ports:
//   clkin        system clock, all logic on the rising edge
//   resetn       asynchronous active-low reset
//   enable       level; high runs gates back-to-back, low idles
//   sig_in       asynchronous signal under test
//   count        rising edges seen in the last completed gate
//   period       clkin cycles between the last two edges of that gate
//   count_valid  one-cycle pulse when count/period/flags update
//   busy         high while a gate is open
//   overflow     edge or period counter saturated in the last gate
//   no_signal    no edges in the last gate
module freq_meter #(
  parameter int GATE_CYCLES = 27000000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clkin,
  input  logic             resetn,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] period,
  output logic             count_valid,
  output logic             busy,
  output logic             overflow,
  output logic             no_signal
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, GATE, REPORT} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   hist;
  logic                   sync_q, rise;

  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt, period_cnt, last_period;
  logic             seen_edge, ovf_int;
  logic             gate_on, report, gate_last;
  logic             edge_sat, per_sat;

  // Synchronizer and edge history run in every state, so a level that was
  // already high before the gate opens is never taken as an edge.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      sync_pipe <= '0;
      hist      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], sig_in};
      hist      <= sync_q;
    end
  end

  assign sync_q = sync_pipe[SYNC_STAGES-1];
  assign rise   = sync_q & ~hist;

  // FSM state register
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = GATE;
      GATE:    if (!enable)      state_nxt = IDLE;
               else if (gate_last) state_nxt = REPORT;
      REPORT:  state_nxt = enable ? GATE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM decode
  always_comb begin
    gate_on = 1'b0;
    report  = 1'b0;
    case (state)
      GATE:    gate_on = 1'b1;
      REPORT:  report  = 1'b1;
      default: ;
    endcase
  end

  assign gate_last = (gate_cnt == GATE_LAST);
  assign edge_sat  = rise & (edge_cnt == CNT_MAX);
  // Covers both the idle-cycle increment and the +1 folded into last_period
  // on an edge: either way the true interval no longer fits.
  assign per_sat   = seen_edge & (period_cnt == CNT_MAX);

  // Gate datapath; everything is cleared whenever the gate is closed, so each
  // gate starts from zero regardless of how the previous one ended.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      period_cnt  <= '0;
      last_period <= '0;
      seen_edge   <= 1'b0;
      ovf_int     <= 1'b0;
    end else if (gate_on) begin
      gate_cnt <= gate_cnt + GW'(1);
      if (rise) begin
        if (!edge_sat) edge_cnt <= edge_cnt + CNT_W'(1);
        if (seen_edge) last_period <= per_sat ? CNT_MAX : period_cnt + CNT_W'(1);
        seen_edge  <= 1'b1;
        period_cnt <= '0;
      end else if (seen_edge && !per_sat) begin
        period_cnt <= period_cnt + CNT_W'(1);
      end
      if (edge_sat || per_sat) ovf_int <= 1'b1;
    end else begin
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      period_cnt  <= '0;
      last_period <= '0;
      seen_edge   <= 1'b0;
      ovf_int     <= 1'b0;
    end
  end

  // Registered outputs; results move only out of REPORT
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      count       <= '0;
      period      <= '0;
      overflow    <= 1'b0;
      no_signal   <= 1'b0;
      count_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      count_valid <= report;
      busy        <= (state_nxt == GATE);
      if (report) begin
        count     <= edge_cnt;
        period    <= last_period;
        overflow  <= ovf_int;
        no_signal <= (edge_cnt == '0);
      end
    end
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the clock chain's divided outputs (LED clock, divider taps, PLL divided output) from the other end: it samples a slow square wave as data in the single system clock domain.
- Counts rising edges over a fixed gate window and reports the last full period in system clocks.
- Lets a board check the PLL/divider chain in hardware without a scope; results go to a UART/LED readout block.

Parameters:
- GATE_CYCLES, 27000000, gate window length in clkin cycles (>= 2).
- CNT_W, 32, width of edge count and period outputs.
- SYNC_STAGES, 2, flops in the sig_in synchronizer (>= 2).

Ports:
- clkin  input  1  system clock, all logic on rising edge.
- resetn  input  1  asynchronous active-low reset, deassertion synchronous to clkin externally.
- enable  input  1  level; high = run gates back-to-back, low = idle.
- sig_in  input  1  asynchronous square wave under test.
- count  output  CNT_W  rising edges in the last completed gate.
- period  output  CNT_W  clkin cycles between the last two rising edges inside the last gate.
- count_valid  output  1  one-cycle pulse when count/period/flags update.
- busy  output  1  high while a gate is open.
- overflow  output  1  edge or period counter saturated in the last gate.
- no_signal  output  1  zero edges in the last gate.

Behaviour:
- Reset (async, resetn=0):
  - all outputs 0; synchronizer flops 0; edge-detect history 0.
  - FSM to IDLE; gate, edge and period counters 0.
- Synchronizer:
  - SYNC_STAGES flops, then a history flop.
  - rise = sync_q & ~hist.
  - Latency from sig_in edge to rise = SYNC_STAGES+1 cycles.
  - Runs in all states, so entering GATE never creates a false edge.
- FSM states: IDLE, GATE, REPORT.
  - IDLE: busy=0. If enable=1, next cycle GATE; gate_cnt=0, edge_cnt=0, period_cnt=0, last_period=0, seen_edge=0.
  - GATE: busy=1, gate_cnt increments each cycle.
    - A rise in any GATE cycle, including gate_cnt==GATE_CYCLES-1, increments edge_cnt.
    - edge_cnt saturates at all-ones and sets ovf_int.
    - When gate_cnt==GATE_CYCLES-1, next state is REPORT.
  - REPORT (exactly one cycle):
    - count<=edge_cnt; period<=last_period; overflow<=ovf_int; no_signal<=(edge_cnt==0); count_valid=1.
    - Next state: GATE (counters cleared as on IDLE exit) if enable=1, else IDLE.
    - A rise during REPORT is not counted: one dead cycle per window, accepted.
- Period measurement, within GATE only:
  - period_cnt increments every cycle after the first rise (seen_edge=1), saturating at all-ones; saturation sets ovf_int.
  - On each subsequent rise: last_period<=period_cnt+1 (saturating), then period_cnt<=0.
  - Fewer than 2 rises in the gate leaves last_period=0.
- enable drops during GATE:
  - abort to IDLE next cycle with no count_valid.
  - count/period/flags hold their previous values; busy falls.
- Simultaneous events: a rise on the final gate cycle is included in count and period before REPORT latches.
- Outputs are registered; they change only in REPORT or on reset.
- Edge counter width is CNT_W. If GATE_CYCLES exceeds the CNT_W range, saturation handles it and there is no wrap-around anywhere.

Test Plan:
- GATE_CYCLES=1000, sig_in period 10 (5 high/5 low), enable=1 -> count_valid every 1001 cycles; count=100, period=10, no_signal=0, overflow=0.
- sig_in held 0 then held 1, GATE_CYCLES=1000 -> count=0, period=0, no_signal=1 in both reports; no spurious edge at gate start.
- enable dropped at gate_cnt=500 -> no count_valid; count/period keep prior values; busy=0 within 1 cycle; re-enable -> next report after full 1000-cycle gate.
- CNT_W=4, GATE_CYCLES=100, sig_in period 4 -> count=15, overflow=1. Then sig_in period 40 with CNT_W=4 -> period=15 saturated, overflow=1.
- Single rise aligned to land on gate_cnt==GATE_CYCLES-1 -> count=1, period=0. Rise aligned to land in the REPORT cycle -> not counted.
- resetn pulsed low mid-gate -> all outputs 0 immediately (async); after release with enable=1, first report arrives after 1+GATE_CYCLES+1 cycles with correct count.
